// File: rtl/parking_fee_calc_pkg.sv
// Shared types and default tariff constants for the parking fee billing stage.
package parking_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    PRICE  = 2'd2,
    VALID  = 2'd3
  } state_t;

  localparam int SPOT_W = 2;

  localparam int unsigned DEF_CYCLES_PER_UNIT = 100000000;
  localparam int unsigned DEF_FREE_UNITS      = 1;
  localparam int unsigned DEF_TIER_UNITS      = 4;
  localparam int unsigned DEF_RATE_LOW        = 2;
  localparam int unsigned DEF_RATE_HIGH       = 5;

endpackage

// File: rtl/parking_fee_calc_if.sv
// Exit request / fee handshake bundle between the parking circuit, this stage and the payment logic.
interface parking_fee_if
  import parking_pkg::*;
#(
  parameter int TIME_W = 64,
  parameter int FEE_W  = 16
);

  logic              exit_req;
  logic [SPOT_W-1:0] spot_sel;
  logic [TIME_W-1:0] spot0_time;
  logic [TIME_W-1:0] spot1_time;
  logic [TIME_W-1:0] spot2_time;
  logic [TIME_W-1:0] spot3_time;
  logic              fee_ack;
  logic [FEE_W-1:0]  fee;
  logic [SPOT_W-1:0] fee_spot;
  logic [TIME_W-1:0] units;
  logic              fee_valid;
  logic              fee_sat;
  logic              busy;
  logic              req_drop;

  modport master (
    output exit_req, spot_sel, spot0_time, spot1_time, spot2_time, spot3_time, fee_ack,
    input  fee, fee_spot, units, fee_valid, fee_sat, busy, req_drop
  );

  modport slave (
    input  exit_req, spot_sel, spot0_time, spot1_time, spot2_time, spot3_time, fee_ack,
    output fee, fee_spot, units, fee_valid, fee_sat, busy, req_drop
  );

endinterface

// File: rtl/parking_fee_calc_seq_divider.sv
// Restoring shift-subtract divider: loads on start, then produces one quotient bit per edge
// for TIME_W edges; done is high during the edge that computes the final bit.
module seq_divider #(
  parameter int TIME_W = 64
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [TIME_W-1:0] dividend,
  input  logic [TIME_W-1:0] divisor,
  output logic [TIME_W-1:0] quotient,
  output logic [TIME_W-1:0] remainder,
  output logic              done
);

  localparam int CNT_W = (TIME_W > 1) ? $clog2(TIME_W) : 1;

  logic [TIME_W-1:0] r_quo;
  logic [TIME_W-1:0] r_rem;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_run;

  logic [TIME_W:0]   w_rem_sh;
  logic [TIME_W:0]   w_diff;
  logic              w_ge;
  logic              w_last;

  // The partial remainder borrows the next dividend bit from the top of the quotient register.
  assign w_rem_sh = {r_rem, r_quo[TIME_W-1]};
  assign w_diff   = w_rem_sh - {1'b0, divisor};
  assign w_ge     = ~w_diff[TIME_W];
  assign w_last   = (r_cnt == CNT_W'(TIME_W - 1));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_quo <= '0;
      r_rem <= '0;
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (start) begin
      r_quo <= dividend;
      r_rem <= '0;
      r_cnt <= '0;
      r_run <= 1'b1;
    end else if (r_run) begin
      r_rem <= w_ge ? w_diff[TIME_W-1:0] : w_rem_sh[TIME_W-1:0];
      r_quo <= {r_quo[TIME_W-2:0], w_ge};
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_last) r_run <= 1'b0;
    end
  end

  assign quotient  = r_quo;
  assign remainder = r_rem;
  assign done      = r_run & w_last;

endmodule

// File: rtl/parking_fee_calc.sv
// Billing stage: divides a vacated spot's dwell time into billing units (rounded up),
// applies the free allowance and two-tier rate, and offers a saturated fee over valid/ack.
module parking_fee_calc
  import parking_pkg::*;
#(
  parameter int          TIME_W          = 64,
  parameter int          FEE_W           = 16,
  parameter int unsigned CYCLES_PER_UNIT = DEF_CYCLES_PER_UNIT,
  parameter int unsigned FREE_UNITS      = DEF_FREE_UNITS,
  parameter int unsigned TIER_UNITS      = DEF_TIER_UNITS,
  parameter int unsigned RATE_LOW        = DEF_RATE_LOW,
  parameter int unsigned RATE_HIGH       = DEF_RATE_HIGH
) (
  input  logic         CLK,
  input  logic         RST,
  parking_fee_if.slave bus
);

  localparam int EXT_W = TIME_W + 8;

  function automatic logic [TIME_W-1:0] round_up(input logic [TIME_W-1:0] q,
                                                  input logic [TIME_W-1:0] r);
    if (r == '0) return q;
    if (&q) return q;
    return q + TIME_W'(1);
  endfunction

  function automatic logic [EXT_W-1:0] tier_fee(input logic [TIME_W-1:0] u);
    logic [EXT_W-1:0] b;
    logic [EXT_W-1:0] lo;
    logic [EXT_W-1:0] hi;
    if (u <= TIME_W'(FREE_UNITS)) return '0;
    b  = EXT_W'(u) - EXT_W'(FREE_UNITS);
    lo = (b < EXT_W'(TIER_UNITS)) ? b : EXT_W'(TIER_UNITS);
    hi = b - lo;
    return lo * EXT_W'(RATE_LOW) + hi * EXT_W'(RATE_HIGH);
  endfunction

  // Returns {saturated, fee}.
  function automatic logic [FEE_W:0] sat_fee(input logic [EXT_W-1:0] f);
    if (f > EXT_W'({FEE_W{1'b1}})) return {1'b1, {FEE_W{1'b1}}};
    return {1'b0, f[FEE_W-1:0]};
  endfunction

  state_t            r_state;
  logic [SPOT_W-1:0] r_spot;
  logic [FEE_W-1:0]  r_fee;
  logic [SPOT_W-1:0] r_fee_spot;
  logic [TIME_W-1:0] r_units;
  logic              r_fee_valid;
  logic              r_fee_sat;
  logic              r_busy;
  logic              r_req_drop;

  logic [TIME_W-1:0] w_dividend;
  logic [TIME_W-1:0] w_quo;
  logic [TIME_W-1:0] w_rem;
  logic              w_div_done;
  logic              w_start;
  logic [TIME_W-1:0] w_units;
  logic [EXT_W-1:0]  w_fee_ext;
  logic [FEE_W-1:0]  w_fee;
  logic              w_sat;

  always_comb begin
    w_dividend = bus.spot0_time;
    case (bus.spot_sel)
      2'd1:    w_dividend = bus.spot1_time;
      2'd2:    w_dividend = bus.spot2_time;
      2'd3:    w_dividend = bus.spot3_time;
      default: w_dividend = bus.spot0_time;
    endcase
  end

  // The divider captures the selected spot time on the same edge the FSM accepts the exit.
  assign w_start = (r_state == IDLE) && bus.exit_req;

  seq_divider #(.TIME_W(TIME_W)) u_div (
    .CLK       (CLK),
    .RST       (RST),
    .start     (w_start),
    .dividend  (w_dividend),
    .divisor   (TIME_W'(CYCLES_PER_UNIT)),
    .quotient  (w_quo),
    .remainder (w_rem),
    .done      (w_div_done)
  );

  assign w_units          = round_up(w_quo, w_rem);
  assign w_fee_ext        = tier_fee(w_units);
  assign {w_sat, w_fee}   = sat_fee(w_fee_ext);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state     <= IDLE;
      r_spot      <= '0;
      r_fee       <= '0;
      r_fee_spot  <= '0;
      r_units     <= '0;
      r_fee_valid <= 1'b0;
      r_fee_sat   <= 1'b0;
      r_busy      <= 1'b0;
      r_req_drop  <= 1'b0;
    end else begin
      r_req_drop <= bus.exit_req && (r_state != IDLE);
      case (r_state)
        IDLE: begin
          if (bus.exit_req) begin
            r_spot  <= bus.spot_sel;
            r_busy  <= 1'b1;
            r_state <= DIVIDE;
          end
        end
        DIVIDE: begin
          if (w_div_done) r_state <= PRICE;
        end
        PRICE: begin
          r_fee       <= w_fee;
          r_fee_sat   <= w_sat;
          r_units     <= w_units;
          r_fee_spot  <= r_spot;
          r_fee_valid <= 1'b1;
          r_state     <= VALID;
        end
        VALID: begin
          if (bus.fee_ack) begin
            r_fee_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.fee       = r_fee;
  assign bus.fee_spot  = r_fee_spot;
  assign bus.units     = r_units;
  assign bus.fee_valid = r_fee_valid;
  assign bus.fee_sat   = r_fee_sat;
  assign bus.busy      = r_busy;
  assign bus.req_drop  = r_req_drop;

endmodule

// File: tb/tb_parking_fee_calc.sv
// Directed bench for parking_fee_calc with CYCLES_PER_UNIT=10 and default tariff.
module tb_parking_fee_calc;
  import parking_pkg::*;

  localparam int TIME_W = 64;
  localparam int FEE_W  = 16;
  localparam int LAT    = TIME_W + 1;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  parking_fee_if #(.TIME_W(TIME_W), .FEE_W(FEE_W)) bus ();

  parking_fee_calc #(
    .TIME_W(TIME_W), .FEE_W(FEE_W), .CYCLES_PER_UNIT(10),
    .FREE_UNITS(1), .TIER_UNITS(4), .RATE_LOW(2), .RATE_HIGH(5)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef struct {
    logic [1:0]  sel;
    logic [63:0] t;
    logic [63:0] eu;
    logic [15:0] ef;
    logic        es;
  } vec_t;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic set_times(input logic [1:0] sel, input logic [63:0] t, input logic [63:0] junk);
    bus.spot0_time = (sel == 2'd0) ? t : junk;
    bus.spot1_time = (sel == 2'd1) ? t : junk;
    bus.spot2_time = (sel == 2'd2) ? t : junk;
    bus.spot3_time = (sel == 2'd3) ? t : junk;
  endtask

  // Issues the exit pulse; returns #1 after the accepting edge with spot times scrambled.
  task automatic request(input logic [1:0] sel, input logic [63:0] t);
    set_times(sel, t, 64'd12345);
    bus.spot_sel = sel;
    bus.exit_req = 1'b1;
    @(posedge CLK);
    #1;
    bus.exit_req = 1'b0;
    bus.spot_sel = ~sel;
    set_times(sel, 64'd999999, 64'd777);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.fee_valid && n < 200) begin
      @(posedge CLK);
      #1;
      n++;
    end
  endtask

  task automatic ack();
    bus.fee_ack = 1'b1;
    @(posedge CLK);
    #1;
    bus.fee_ack = 1'b0;
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int n;
    request(v.sel, v.t);
    wait_valid(n);
    check({tag, ".latency"}, 64'(n), 64'(LAT));
    check({tag, ".units"}, bus.units, v.eu);
    check({tag, ".fee"}, 64'(bus.fee), 64'(v.ef));
    check({tag, ".fee_spot"}, 64'(bus.fee_spot), 64'(v.sel));
    check({tag, ".fee_sat"}, 64'(bus.fee_sat), 64'(v.es));
    ack();
    check({tag, ".valid_fall"}, 64'(bus.fee_valid), 64'd0);
    check({tag, ".busy_fall"}, 64'(bus.busy), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".fee"}, 64'(bus.fee), 64'd0);
    check({tag, ".fee_spot"}, 64'(bus.fee_spot), 64'd0);
    check({tag, ".units"}, bus.units, 64'd0);
    check({tag, ".fee_valid"}, 64'(bus.fee_valid), 64'd0);
    check({tag, ".fee_sat"}, 64'(bus.fee_sat), 64'd0);
    check({tag, ".busy"}, 64'(bus.busy), 64'd0);
    check({tag, ".req_drop"}, 64'(bus.req_drop), 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[11];
    int   n;
    logic [15:0] f0;
    logic [63:0] u0;

    vecs[0]  = '{sel: 2'd1, t: 64'd0,      eu: 64'd0,      ef: 16'd0,     es: 1'b0};
    vecs[1]  = '{sel: 2'd2, t: 64'd25,     eu: 64'd3,      ef: 16'd4,     es: 1'b0};
    vecs[2]  = '{sel: 2'd0, t: 64'd100,    eu: 64'd10,     ef: 16'd33,    es: 1'b0};
    vecs[3]  = '{sel: 2'd3, t: '1,         eu: 64'd1844674407370955162, ef: 16'hFFFF, es: 1'b1};
    vecs[4]  = '{sel: 2'd0, t: 64'd10,     eu: 64'd1,      ef: 16'd0,     es: 1'b0};
    vecs[5]  = '{sel: 2'd1, t: 64'd11,     eu: 64'd2,      ef: 16'd2,     es: 1'b0};
    vecs[6]  = '{sel: 2'd2, t: 64'd50,     eu: 64'd5,      ef: 16'd8,     es: 1'b0};
    vecs[7]  = '{sel: 2'd3, t: 64'd51,     eu: 64'd6,      ef: 16'd13,    es: 1'b0};
    vecs[8]  = '{sel: 2'd0, t: 64'd1,      eu: 64'd1,      ef: 16'd0,     es: 1'b0};
    vecs[9]  = '{sel: 2'd1, t: 64'd131100, eu: 64'd13110,  ef: 16'd65533, es: 1'b0};
    vecs[10] = '{sel: 2'd2, t: 64'd131110, eu: 64'd13111,  ef: 16'hFFFF,  es: 1'b1};

    bus.exit_req = 1'b0;
    bus.spot_sel = 2'd0;
    bus.fee_ack  = 1'b0;
    set_times(2'd0, 64'd0, 64'd0);

    #12;
    check_all_zero("reset");
    RST = 1'b1;
    @(posedge CLK);
    #1;

    for (int i = 0; i < 11; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Fee held across a long ack stall; stray acks outside VALID are harmless.
    bus.fee_ack = 1'b1;
    request(2'd0, 64'd100);
    check("stall.busy_rise", 64'(bus.busy), 64'd1);
    wait_valid(n);
    check("stall.latency", 64'(n), 64'(LAT));
    f0 = bus.fee;
    u0 = bus.units;
    check("stall.fee", 64'(f0), 64'd33);
    check("stall.units", u0, 64'd10);
    bus.fee_ack = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK);
      #1;
      check($sformatf("stall.hold%0d", i),
            {46'd0, bus.fee_valid, bus.fee},
            {46'd0, 1'b1, 16'd33});
    end
    ack();
    check("stall.valid_fall", 64'(bus.fee_valid), 64'd0);
    check("stall.fee_retained", 64'(bus.fee), 64'd33);

    // Exit requests while busy are dropped, including on the ack edge.
    request(2'd2, 64'd25);
    repeat (5) begin
      @(posedge CLK);
      #1;
    end
    set_times(2'd3, 64'd1000, 64'd1000);
    bus.spot_sel = 2'd3;
    bus.exit_req = 1'b1;
    @(posedge CLK);
    #1;
    bus.exit_req = 1'b0;
    check("drop1.req_drop", 64'(bus.req_drop), 64'd1);
    check("drop1.busy", 64'(bus.busy), 64'd1);
    @(posedge CLK);
    #1;
    check("drop1.req_drop_fall", 64'(bus.req_drop), 64'd0);
    wait_valid(n);
    check("drop1.latency", 64'(n + 7), 64'(LAT));
    check("drop1.units", bus.units, 64'd3);
    check("drop1.fee", 64'(bus.fee), 64'd4);
    check("drop1.fee_spot", 64'(bus.fee_spot), 64'd2);
    bus.fee_ack  = 1'b1;
    bus.exit_req = 1'b1;
    bus.spot_sel = 2'd0;
    set_times(2'd0, 64'd10, 64'd10);
    @(posedge CLK);
    #1;
    bus.fee_ack  = 1'b0;
    bus.exit_req = 1'b0;
    check("drop2.req_drop", 64'(bus.req_drop), 64'd1);
    check("drop2.valid_fall", 64'(bus.fee_valid), 64'd0);
    check("drop2.busy", 64'(bus.busy), 64'd0);
    @(posedge CLK);
    #1;
    check("drop2.req_drop_fall", 64'(bus.req_drop), 64'd0);
    check("drop2.not_queued", 64'(bus.busy), 64'd0);
    check("drop2.units_kept", bus.units, 64'd3);

    // Asynchronous reset in the middle of a division.
    request(2'd3, '1);
    repeat (10) @(posedge CLK);
    #2;
    RST = 1'b0;
    #1;
    check_all_zero("midrst");
    #2;
    RST = 1'b1;
    @(posedge CLK);
    #1;
    check("midrst.idle", 64'(bus.busy), 64'd0);
    run_vec("postrst", '{sel: 2'd0, t: 64'd10, eu: 64'd1, ef: 16'd0, es: 1'b0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/parking_fee_calc.md
Name: parking_fee_calc

Overview:
- Downstream billing stage for the parking `circuit`.
- On each exit pulse, it captures the selected spot's elapsed-time counter (`spotN_time`, in clock cycles) and converts it to billing units, rounding up.
- It applies a free allowance and a two-tier rate, then presents a saturated fee to the payment/display logic over a valid/ack handshake.

Parameters:
- TIME_W, 64, width of spot time counters and unit count.
- FEE_W, 16, width of fee output.
- CYCLES_PER_UNIT, 100000000, clock cycles per billing unit; must be >= 1.
- FREE_UNITS, 1, units charged at zero.
- TIER_UNITS, 4, billable units charged at RATE_LOW before RATE_HIGH applies.
- RATE_LOW, 2, fee per unit in the low tier.
- RATE_HIGH, 5, fee per unit above the tier.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  reset, asynchronous, active-low.
- exit_req  in  1  one-cycle exit pulse; same timing as the circuit's `exit`.
- spot_sel  in  2  spot being vacated; sampled with exit_req.
- spot0_time..spot3_time  in  TIME_W each  elapsed cycles per spot.
- fee_ack  in  1  consumer accepts the fee.
- fee  out  FEE_W  computed fee.
- fee_spot  out  2  spot the fee belongs to.
- units  out  TIME_W  billed units (rounded up).
- fee_valid  out  1  fee/fee_spot/units are valid.
- fee_sat  out  1  fee was clipped to its maximum; valid with fee_valid.
- busy  out  1  high in any state other than IDLE.
- req_drop  out  1  one-cycle pulse when an exit_req is ignored.

Behaviour:
- Reset (RST=0, takes effect immediately, independent of CLK):
  - state IDLE.
  - fee, fee_spot, units, fee_valid, fee_sat, busy, req_drop all 0.
  - Divider registers cleared.
- FSM states: IDLE -> DIVIDE -> PRICE -> VALID -> IDLE.
- IDLE:
  - On an edge with exit_req=1: latch spot_time[spot_sel] as the dividend and latch spot_sel.
  - Clear the iteration counter; go to DIVIDE.
- DIVIDE:
  - Restoring shift-subtract division by CYCLES_PER_UNIT, one quotient bit per edge, exactly TIME_W edges.
  - Then go to PRICE.
- PRICE, single edge:
  - Rounding: u = q + (r != 0). If q is all-ones and r != 0, u saturates at all-ones.
  - If u <= FREE_UNITS: fee = 0.
  - Otherwise b = u - FREE_UNITS, lo = min(b, TIER_UNITS), hi = b - lo, and fee = lo*RATE_LOW + hi*RATE_HIGH.
  - Fee arithmetic is done at TIME_W+8 bits minimum. If the result exceeds 2^FEE_W-1, fee = 2^FEE_W-1 and fee_sat = 1.
  - Register fee, fee_spot, units; go to VALID.
- Latency: fee_valid rises after the (TIME_W+1)th edge following the edge that sampled exit_req, i.e. 65 edges at default.
- VALID:
  - fee_valid=1 and outputs held stable until an edge with fee_ack=1.
  - That edge: fee_valid -> 0, state -> IDLE. fee/fee_spot/units/fee_sat retain their values until the next PRICE.
- Handshake:
  - fee_ack outside VALID is ignored.
  - An exit_req on any edge where state != IDLE is not queued and req_drop pulses on the next cycle. This includes the edge where fee_ack completes VALID.
- Spot time inputs are sampled only at the accepting edge; later changes have no effect on the result.
- Zero dwell (time=0) gives units=0, fee=0.

Decomposition:
- Shared package parking_pkg holds:
  - the state enum (IDLE, DIVIDE, PRICE, VALID);
  - default constants for the rates, FREE_UNITS, TIER_UNITS and CYCLES_PER_UNIT;
  - the spot-index width (2).
- One sub-module, seq_divider, is natural:
  - start pulse, TIME_W-bit dividend/divisor, quotient/remainder outputs, done pulse, same CLK/RST;
  - the FSM drives start and waits for done.

Test Plan (CYCLES_PER_UNIT=10, defaults otherwise):
- spot1_time=0, exit_req with spot_sel=1 -> after 65 edges fee_valid=1, units=0, fee=0, fee_spot=1, fee_sat=0.
- spot2_time=25, spot_sel=2 -> units=3, fee=4, fee_spot=2; fee_valid rises exactly 65 edges after the request edge.
- spot0_time=100 -> units=10, fee=33; fee_ack held low for 20 cycles -> outputs stable throughout; fee_valid falls on the ack edge.
- spot3_time=all-ones -> units=1844674407370955162 (rounded up), fee=65535, fee_sat=1.
- exit_req during DIVIDE, and again on the fee_ack edge -> req_drop pulses each time; the in-flight result is unchanged; state returns to IDLE.
- RST=0 mid-DIVIDE -> all outputs 0 immediately without a clock edge; release RST, issue spot0_time=10 -> units=1, fee=0.
